// File: rtl/reg_file_mp_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_mp_pkg
// Shared definitions for the multi-port register file:
//   BYTE_W  - width of one byte lane (write enable / parity granularity)
//   state_t - clear-sequencer state encoding (IDLE, CLEAR)
// Optional feature macro used by the including files: REG_FILE_MP_PARITY_EN
// -----------------------------------------------------------------------------
package reg_file_mp_pkg;

   localparam int BYTE_W = 8;

   typedef logic [0:0] state_t;

   localparam state_t IDLE  = 1'b0;
   localparam state_t CLEAR = 1'b1;

endpackage : reg_file_mp_pkg

// File: rtl/reg_file_mp_rdport.sv
// -----------------------------------------------------------------------------
// reg_file_mp_rdport
// One registered read port of reg_file_mp. Merges a same-cycle write into the
// stored entry (write-first), returns 0 for out-of-range addresses and holds
// its data between accepted reads.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   i_en, i_addr        read request and address
//   i_busy              clear sequence running; requests are dropped
//   i_entry             stored entry at i_addr (0 when out of range)
//   i_wr_fire, i_wr_*   accepted write of this cycle, used for bypass
//   o_oor               this cycle's accepted read is out of range
//   o_valid, o_data     one-cycle-latency read result
//   i_entry_par, o_perr stored parity / parity error (REG_FILE_MP_PARITY_EN)
// -----------------------------------------------------------------------------
module reg_file_mp_rdport
   import reg_file_mp_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_en,
   input  logic                     i_busy,
   input  logic [ADDR_W-1:0]        i_addr,
   input  logic [WIDTH-1:0]         i_entry,
   input  logic                     i_wr_fire,
   input  logic [ADDR_W-1:0]        i_wr_addr,
   input  logic [WIDTH-1:0]         i_wr_data,
   input  logic [WIDTH/BYTE_W-1:0]  i_wr_be,
`ifdef REG_FILE_MP_PARITY_EN
   input  logic [WIDTH/BYTE_W-1:0]  i_entry_par,
   output logic                     o_perr,
`endif
   output logic                     o_oor,
   output logic                     o_valid,
   output logic [WIDTH-1:0]         o_data
);

   localparam int               NB      = WIDTH / BYTE_W;
   localparam logic [ADDR_W:0]  DEPTH_V = (ADDR_W+1)'(DEPTH);

   logic             w_fire;
   logic             w_in_range;
   logic [NB-1:0]    w_byp;
   logic [WIDTH-1:0] w_merged;

   assign w_fire     = i_en & ~i_busy;
   assign w_in_range = ({1'b0, i_addr} < DEPTH_V);
   assign o_oor      = w_fire & ~w_in_range;

   // Byte lanes that take the in-flight write data instead of the stored entry.
   assign w_byp = {NB{i_wr_fire && (i_wr_addr == i_addr)}} & i_wr_be;

   // NOTE: every combinational output gets a default before any conditional
   // update, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_merged = i_entry;
      for (int b = 0; b < NB; b++) begin
         if (w_byp[b]) w_merged[b*BYTE_W +: BYTE_W] = i_wr_data[b*BYTE_W +: BYTE_W];
      end
   end

   // NOTE: clocked state is updated with non-blocking assignments only, so
   // every register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_valid <= 1'b0;
         o_data  <= '0;
      end else begin
         o_valid <= w_fire;
         if (w_fire) o_data <= w_in_range ? w_merged : '0;
      end
   end

`ifdef REG_FILE_MP_PARITY_EN
   logic [NB-1:0] w_calc_par;

   always_comb begin
      w_calc_par = '0;
      for (int b = 0; b < NB; b++) w_calc_par[b] = ^i_entry[b*BYTE_W +: BYTE_W];
   end

   // Bypassed lanes come straight from wr_data and never report an error.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_perr <= 1'b0;
      end else if (w_fire) begin
         o_perr <= w_in_range & (|((i_entry_par ^ w_calc_par) & ~w_byp));
      end
   end
`endif

endmodule : reg_file_mp_rdport

// File: rtl/reg_file_mp.sv
// -----------------------------------------------------------------------------
// reg_file_mp
// WIDTH x DEPTH register file with one byte-enabled write port, two
// independent registered read ports (write-first bypass), out-of-range
// detection and a sequential clear engine (one entry per cycle).
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data/wr_be write port with byte enables
//   rdN_en/rdN_addr             read requests, N = 0, 1
//   rdN_data/rdN_valid          read result, one cycle after the request
//   clr_req, busy               start clear / clear in progress
//   addr_err                    out-of-range access seen in the previous cycle
//   rdN_perr                    parity error (only with REG_FILE_MP_PARITY_EN)
//
// Optional feature macro: REG_FILE_MP_PARITY_EN (even parity per byte).
// -----------------------------------------------------------------------------
module reg_file_mp
   import reg_file_mp_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [WIDTH/BYTE_W-1:0]  wr_be,
   input  logic                     rd0_en,
   input  logic [ADDR_W-1:0]        rd0_addr,
   output logic [WIDTH-1:0]         rd0_data,
   output logic                     rd0_valid,
   input  logic                     rd1_en,
   input  logic [ADDR_W-1:0]        rd1_addr,
   output logic [WIDTH-1:0]         rd1_data,
   output logic                     rd1_valid,
   input  logic                     clr_req,
   output logic                     busy,
   output logic                     addr_err
`ifdef REG_FILE_MP_PARITY_EN
   ,
   output logic                     rd0_perr,
   output logic                     rd1_perr
`endif
);

   localparam int                NB       = WIDTH / BYTE_W;
   localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   state_t            r_state;
   logic [ADDR_W-1:0] r_clr_cnt;
   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic              r_addr_err;

   logic              w_busy;
   logic              w_wr_in_range;
   logic              w_wr_fire;
   logic              w_wr_oor;
   logic              w_rd0_in_range;
   logic              w_rd1_in_range;
   logic [WIDTH-1:0]  w_rd0_entry;
   logic [WIDTH-1:0]  w_rd1_entry;
   logic              w_rd0_oor;
   logic              w_rd1_oor;

   assign w_busy         = (r_state == CLEAR);
   assign busy           = w_busy;
   assign addr_err       = r_addr_err;

   assign w_wr_in_range  = ({1'b0, wr_addr} < DEPTH_V);
   assign w_wr_fire      = wr_en & ~w_busy & w_wr_in_range;
   // Writes dropped because of busy are silent, so they never flag addr_err.
   assign w_wr_oor       = wr_en & ~w_busy & ~w_wr_in_range;

   // Guard the array index so out-of-range addresses never read past the end.
   assign w_rd0_in_range = ({1'b0, rd0_addr} < DEPTH_V);
   assign w_rd1_in_range = ({1'b0, rd1_addr} < DEPTH_V);
   assign w_rd0_entry    = w_rd0_in_range ? r_mem[rd0_addr] : '0;
   assign w_rd1_entry    = w_rd1_in_range ? r_mem[rd1_addr] : '0;

   // Clear sequencer: busy covers exactly DEPTH cycles, one entry per cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_clr_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (clr_req) begin
                  r_state   <= CLEAR;
                  r_clr_cnt <= '0;
               end
            end
            CLEAR: begin
               if (r_clr_cnt == LAST_IDX) begin
                  r_state   <= IDLE;
                  r_clr_cnt <= '0;
               end else begin
                  r_clr_cnt <= r_clr_cnt + 1'b1;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_clr_cnt <= '0;
            end
         endcase
      end
   end

   // NOTE: the storage array is reset on purpose; reset must leave every entry
   // at zero, which rules out a plain RAM macro for this block.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_busy) begin
         r_mem[r_clr_cnt] <= '0;
      end else if (w_wr_fire) begin
         for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) r_mem[wr_addr][b*BYTE_W +: BYTE_W] <= wr_data[b*BYTE_W +: BYTE_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_addr_err <= 1'b0;
      else      r_addr_err <= w_wr_oor | w_rd0_oor | w_rd1_oor;
   end

`ifdef REG_FILE_MP_PARITY_EN
   logic [NB-1:0] r_par [DEPTH];
   logic [NB-1:0] w_wr_par;
   logic [NB-1:0] w_rd0_par;
   logic [NB-1:0] w_rd1_par;

   // Even parity: stored bit makes the byte plus parity carry an even 1-count.
   always_comb begin
      w_wr_par = '0;
      for (int b = 0; b < NB; b++) w_wr_par[b] = ^wr_data[b*BYTE_W +: BYTE_W];
   end

   assign w_rd0_par = w_rd0_in_range ? r_par[rd0_addr] : '0;
   assign w_rd1_par = w_rd1_in_range ? r_par[rd1_addr] : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) r_par[i] <= '0;
      end else if (w_busy) begin
         r_par[r_clr_cnt] <= '0;
      end else if (w_wr_fire) begin
         for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) r_par[wr_addr][b] <= w_wr_par[b];
         end
      end
   end
`endif

   reg_file_mp_rdport #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_rd0 (
      .clk         (clk),
      .rst         (rst),
      .i_en        (rd0_en),
      .i_busy      (w_busy),
      .i_addr      (rd0_addr),
      .i_entry     (w_rd0_entry),
      .i_wr_fire   (w_wr_fire),
      .i_wr_addr   (wr_addr),
      .i_wr_data   (wr_data),
      .i_wr_be     (wr_be),
`ifdef REG_FILE_MP_PARITY_EN
      .i_entry_par (w_rd0_par),
      .o_perr      (rd0_perr),
`endif
      .o_oor       (w_rd0_oor),
      .o_valid     (rd0_valid),
      .o_data      (rd0_data)
   );

   reg_file_mp_rdport #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_rd1 (
      .clk         (clk),
      .rst         (rst),
      .i_en        (rd1_en),
      .i_busy      (w_busy),
      .i_addr      (rd1_addr),
      .i_entry     (w_rd1_entry),
      .i_wr_fire   (w_wr_fire),
      .i_wr_addr   (wr_addr),
      .i_wr_data   (wr_data),
      .i_wr_be     (wr_be),
`ifdef REG_FILE_MP_PARITY_EN
      .i_entry_par (w_rd1_par),
      .o_perr      (rd1_perr),
`endif
      .o_oor       (w_rd1_oor),
      .o_valid     (rd1_valid),
      .o_data      (rd1_data)
   );

endmodule : reg_file_mp
